// File: rtl/vga_pkg.sv
// Shared VGA timing constants, VRAM defaults and arbiter types used by the
// pixel-fetch and VRAM arbitration logic.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic {
    ACTIVE = 1'b0,
    BLANK  = 1'b1
  } mode_e;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Return-path tag pipe: tracks each issued read for two cycles and steers
// the RAM read data to the owning port as a registered rvalid/rdata pair.
module vram_rd_tag_pipe
  import vga_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  owner_e            issue_owner,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);

  rd_tag_t tag0_q;
  rd_tag_t tag1_q;

  logic to_disp;
  logic to_host;

  assign to_disp = tag1_q.valid && (tag1_q.owner == OWN_DISP);
  assign to_host = tag1_q.valid && (tag1_q.owner == OWN_HOST);

  // tag0 lines up with the RAM command register, tag1 with ram_rdata.
  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      tag0_q      <= '{valid: 1'b0, owner: OWN_DISP};
      tag1_q      <= '{valid: 1'b0, owner: OWN_DISP};
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rdata  <= '0;
    end else begin
      tag0_q      <= '{valid: issue_valid, owner: issue_owner};
      tag1_q      <= tag0_q;
      disp_rvalid <= to_disp;
      host_rvalid <= to_host;
      if (to_disp) disp_rdata <= ram_rdata;
      if (to_host) host_rdata <= ram_rdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between display prefetch and host port on pclk.
// Optional statistics (disp_stall_cnt, host_starved) under VRAM_ARB_STATS_EN.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              blank,
  input  logic              disp_valid,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ready,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       disp_stall_cnt,
  output logic              host_starved
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  mode_e      mode_q, mode_d;
  logic [7:0] starve_q, starve_d;
  logic       disp_gnt, host_gnt;
  logic       rd_issue;
  owner_e     rd_owner;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) mode_q <= ACTIVE;
    else        mode_q <= mode_d;
  end

  // Arbitration always looks at the registered mode, so a blank edge only
  // changes priority from the following cycle.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves a signal unassigned and infers a latch.
  always_comb begin
    mode_d     = blank ? BLANK : ACTIVE;
    disp_ready = 1'b0;
    host_ready = 1'b0;
    if (mode_q == BLANK) begin
      host_ready = host_valid;
      disp_ready = disp_valid && !host_valid;
    end else if (host_valid && (starve_q == LIMIT)) begin
      host_ready = 1'b1;
    end else if (disp_valid) begin
      disp_ready = 1'b1;
    end else begin
      host_ready = host_valid;
    end
  end

  assign disp_gnt = disp_valid && disp_ready;
  assign host_gnt = host_valid && host_ready;
  assign rd_issue = disp_gnt || (host_gnt && !host_we);
  assign rd_owner = host_gnt ? OWN_HOST : OWN_DISP;

  always_comb begin
    starve_d = starve_q;
    if (!host_valid || host_gnt || (mode_q == ACTIVE && blank)) starve_d = '0;
    else if (starve_q != LIMIT)                                 starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      starve_q <= starve_d;
      ram_en   <= disp_gnt || host_gnt;
      ram_we   <= host_gnt && host_we;
      if (host_gnt) begin
        ram_addr  <= host_addr;
        ram_wdata <= host_wdata;
      end else if (disp_gnt) begin
        ram_addr <= disp_addr;
      end
    end
  end

  vram_rd_tag_pipe #(
    .DATA_W(DATA_W)
  ) u_tag_pipe (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .issue_valid(rd_issue),
    .issue_owner(rd_owner),
    .ram_rdata  (ram_rdata),
    .disp_rvalid(disp_rvalid),
    .disp_rdata (disp_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata)
  );

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      disp_stall_cnt <= '0;
      host_starved   <= 1'b0;
    end else begin
      if (disp_valid && !disp_ready && (disp_stall_cnt != 16'hFFFF))
        disp_stall_cnt <= disp_stall_cnt + 16'd1;
      if (starve_d == LIMIT) host_starved <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a cycle-level grant model predicts
// ready/commands/read data; a monitor compares RAM commands and rvalids.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int LIMIT = 8;

  logic        pclk, rst_n, blank;
  logic        disp_valid, disp_ready, disp_rvalid;
  logic [15:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        host_valid, host_we, host_ready, host_rvalid;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        ram_en, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] disp_stall_cnt;
  logic        host_starved;
`endif

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(LIMIT)) dut (
    .pclk(pclk), .rst_n(rst_n), .blank(blank),
    .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_ready(disp_ready),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .disp_stall_cnt(disp_stall_cnt), .host_starved(host_starved)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Synchronous RAM macro model; the shadow copy is the bench's own view.
  logic [7:0] mem    [0:65535];
  logic [7:0] shadow [0:65535];
  initial ram_rdata = 8'h00;
  always @(posedge pclk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct { logic [7:0] data; int due; } rd_exp_t;
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; int due; } cmd_exp_t;

  rd_exp_t  disp_q[$];
  rd_exp_t  host_q[$];
  cmd_exp_t cmd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Reference model state
  bit m_active = 1'b1;
  int m_wait = 0;
  int m_stall = 0;
  bit m_starved = 1'b0;
  bit d_xfer = 1'b0, h_xfer = 1'b0;
  bit obs_d, obs_h;
  logic [15:0] last_addr = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs were set by the caller just after posedge.
  task automatic do_cycle();
    bit e_d, e_h;
    @(negedge pclk);
`ifdef VRAM_ARB_STATS_EN
    check("disp_stall_cnt", disp_stall_cnt, m_stall);
    check("host_starved", host_starved, m_starved);
`endif
    if (!m_active) begin
      e_h = host_valid;
      e_d = disp_valid && !host_valid;
    end else if (host_valid && m_wait == LIMIT) begin
      e_h = 1'b1; e_d = 1'b0;
    end else if (disp_valid) begin
      e_h = 1'b0; e_d = 1'b1;
    end else begin
      e_h = host_valid; e_d = 1'b0;
    end
    obs_d = disp_ready;
    obs_h = host_ready;
    check("disp_ready", disp_ready, e_d);
    check("host_ready", host_ready, e_h);
    d_xfer = disp_valid && e_d;
    h_xfer = host_valid && e_h;
    if (disp_valid && !e_d && m_stall < 65535) m_stall++;
    if (d_xfer) begin
      cmd_q.push_back('{we: 1'b0, addr: disp_addr, wdata: 8'h00, due: cyc + 1});
      disp_q.push_back('{data: shadow[disp_addr], due: cyc + 3});
    end
    if (h_xfer) begin
      cmd_q.push_back('{we: host_we, addr: host_addr, wdata: host_wdata, due: cyc + 1});
      if (host_we) shadow[host_addr] = host_wdata;
      else         host_q.push_back('{data: shadow[host_addr], due: cyc + 3});
    end
    if (!host_valid || e_h || (m_active && blank)) m_wait = 0;
    else if (m_wait < LIMIT) m_wait++;
    if (m_wait == LIMIT) m_starved = 1'b1;
    m_active = !blank;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    disp_valid = 1'b0;
    host_valid = 1'b0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " disp_ready"}, disp_ready, 0);
    check({tag, " host_ready"}, host_ready, 0);
    check({tag, " disp_rvalid"}, disp_rvalid, 0);
    check({tag, " host_rvalid"}, host_rvalid, 0);
    check({tag, " disp_rdata"}, disp_rdata, 0);
    check({tag, " host_rdata"}, host_rdata, 0);
    check({tag, " ram_en"}, ram_en, 0);
    check({tag, " ram_we"}, ram_we, 0);
    check({tag, " ram_addr"}, ram_addr, 0);
    check({tag, " ram_wdata"}, ram_wdata, 0);
`ifdef VRAM_ARB_STATS_EN
    check({tag, " disp_stall_cnt"}, disp_stall_cnt, 0);
    check({tag, " host_starved"}, host_starved, 0);
`endif
  endtask

  task automatic alt_reads(input logic [15:0] a_d, input logic [15:0] a_h,
                           input logic [7:0] x_d, input logic [7:0] x_h);
    idle(2);
    for (int i = 0; i < 6; i++) begin
      disp_valid = (i % 2 == 0);
      host_valid = (i % 2 == 1);
      host_we    = 1'b0;
      disp_addr  = a_d;
      host_addr  = a_h;
      do_cycle();
      check("alt grant", (i % 2 == 0) ? obs_d : obs_h, 1);
    end
    idle(4);
    check("alt disp_rdata", disp_rdata, x_d);
    check("alt host_rdata", host_rdata, x_h);
  endtask

  // Monitor: compares RAM commands and read returns against the queues.
  rd_exp_t  mon_r;
  cmd_exp_t mon_c;
  initial begin
    forever begin
      @(posedge pclk);
      #2;
      if (disp_q.size() > 0 && disp_q[0].due == cyc) begin
        mon_r = disp_q.pop_front();
        check("disp_rvalid", disp_rvalid, 1);
        check("disp_rdata", disp_rdata, mon_r.data);
      end else check("disp_rvalid idle", disp_rvalid, 0);
      if (host_q.size() > 0 && host_q[0].due == cyc) begin
        mon_r = host_q.pop_front();
        check("host_rvalid", host_rvalid, 1);
        check("host_rdata", host_rdata, mon_r.data);
      end else check("host_rvalid idle", host_rvalid, 0);
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        mon_c = cmd_q.pop_front();
        check("ram_en", ram_en, 1);
        check("ram_we", ram_we, mon_c.we);
        check("ram_addr", ram_addr, mon_c.addr);
        if (mon_c.we) check("ram_wdata", ram_wdata, mon_c.wdata);
        last_addr = mon_c.addr;
      end else begin
        check("ram_en idle", ram_en, 0);
        check("ram_we idle", ram_we, 0);
        check("ram_addr hold", ram_addr, last_addr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i);
      shadow[i] = 8'(i);
    end
    rst_n = 1'b0; blank = 1'b0;
    disp_valid = 1'b0; disp_addr = '0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    #1;
    check_all_zero("reset");
    @(negedge pclk);
    rst_n = 1'b1;
    @(posedge pclk);
    #1;

    // Active video, both requesting: host forced through every 9th cycle.
    idle(2);
    disp_valid = 1'b1; disp_addr = 16'h0300;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0301;
    for (int i = 0; i < 27; i++) begin
      do_cycle();
      check("starve host_ready", obs_h, (i % 9 == 8));
      check("starve disp_ready", obs_d, (i % 9 != 8));
    end

    // Blanking: host wins; mode change lags blank by one cycle.
    blank = 1'b1;
    idle(2);
    disp_valid = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      check("blank host_ready", obs_h, 1);
      check("blank disp_ready", obs_d, 0);
    end
    host_valid = 1'b0;
    do_cycle();
    check("blank disp alone", obs_d, 1);
    host_valid = 1'b1; blank = 1'b0;
    do_cycle();
    check("old mode host_ready", obs_h, 1);
    do_cycle();
    check("new mode disp_ready", obs_d, 1);

    // Host write then read-back with exact latency.
    idle(3);
    host_valid = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 8'hA5;
    do_cycle();
    check("wr grant", obs_h, 1);
    check("wr ram_we", ram_we, 1);
    check("wr ram_addr", ram_addr, 16'h0010);
    check("wr ram_wdata", ram_wdata, 8'hA5);
    host_we = 1'b0;
    do_cycle();
    check("rd grant", obs_h, 1);
    idle(1);
    check("rd early rvalid", host_rvalid, 0);
    idle(1);
    check("rd host_rvalid", host_rvalid, 1);
    check("rd host_rdata", host_rdata, 8'hA5);

    // Alternating owners every cycle.
    alt_reads(16'h0100, 16'h0200, 8'h00, 8'h00);
    alt_reads(16'h01A0, 16'h02B0, 8'hA0, 8'hB0);

    // Reset one cycle after a display read grant.
    idle(2);
    disp_valid = 1'b1; disp_addr = 16'h0123;
    do_cycle();
    disp_valid = 1'b0;
    @(posedge pclk);
    #3;
    rst_n = 1'b0;
    disp_q.delete(); host_q.delete(); cmd_q.delete();
    last_addr = 16'h0000;
    m_active = 1'b1; m_wait = 0; m_stall = 0; m_starved = 1'b0;
    d_xfer = 1'b0; h_xfer = 1'b0;
    #1;
    check_all_zero("mid reset");
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_all_zero("held reset");
    rst_n = 1'b1;
    @(posedge pclk);
    #1;
    disp_valid = 1'b1; disp_addr = 16'h0042;
    do_cycle();
    check("post reset grant", obs_d, 1);
    idle(2);
    check("post reset rvalid", disp_rvalid, 1);
    check("post reset rdata", disp_rdata, 8'h42);

    // Refused display cycles during blanking, then a forced host grant.
    blank = 1'b1;
    idle(2);
    disp_valid = 1'b1; disp_addr = 16'h0007;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 16'h0008;
    for (int i = 0; i < 20; i++) do_cycle();
    idle(1);
`ifdef VRAM_ARB_STATS_EN
    check("stall count 20", disp_stall_cnt, 20);
    check("not yet starved", host_starved, 0);
`endif
    blank = 1'b0;
    idle(2);
    disp_valid = 1'b1; host_valid = 1'b1;
    for (int i = 0; i < 9; i++) do_cycle();
    check("forced host grant", obs_h, 1);
    idle(1);
`ifdef VRAM_ARB_STATS_EN
    check("host_starved sticky", host_starved, 1);
`endif

    // Randomized traffic with requests held until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!disp_valid || d_xfer) begin
        disp_valid = ($urandom_range(0, 99) < 60);
        disp_addr  = 16'($urandom_range(0, 31));
      end
      if (!host_valid || h_xfer) begin
        host_valid = ($urandom_range(0, 99) < 50);
        host_we    = ($urandom_range(0, 99) < 40);
        host_addr  = 16'($urandom_range(0, 31));
        host_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 99) < 3) blank = ~blank;
      do_cycle();
    end
    idle(5);
    check("disp_q drained", disp_q.size(), 0);
    check("host_q drained", host_q.size(), 0);
    check("cmd_q drained", cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between two requesters:
  - the display pixel-fetch path, which feeds the line prefetch ahead of the VGA timing generator;
  - a host port for framebuffer reads and writes.
- Display has priority during active video, with bounded host starvation. Host has priority during blanking.
- Sits between the pixel-clock domain timing logic and the VRAM macro; runs entirely on pclk.

Parameters:
- ADDR_W, 16, VRAM word address width.
- DATA_W, 8, VRAM word width (8 packed 1-bit pixels).
- STARVE_LIMIT, 8, max consecutive cycles a valid host request may be refused during active video (range 1..255).

Ports:
- pclk  in  1  pixel clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- blank  in  1  high during horizontal or vertical blanking, from the timing generator.
- disp_valid  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_ready  out  1  display request accepted this cycle.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DATA_W  display read data.
- host_valid  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- ram_en, ram_we  out  1  RAM command; registered.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en with ram_we = 0.

Behaviour:
- Reset values: all outputs 0. Mode = ACTIVE; starve counter = 0; tag pipe empty.
- Handshake: a request transfers when valid && ready in the same cycle.
  - ready is combinational from the current valid inputs and registered state.
  - Requesters hold addr/data/we stable while valid && !ready.
  - At most one grant per cycle.
- Mode register (state machine):
  - ACTIVE -> BLANK on a cycle where blank = 1; BLANK -> ACTIVE where blank = 0.
  - The registered mode updates one cycle after blank changes; arbitration uses the registered mode.
- ACTIVE grant rule:
  - If host_valid and starve counter == STARVE_LIMIT: grant host, disp_ready = 0.
  - Else if disp_valid: grant display.
  - Else if host_valid: grant host.
- BLANK grant rule: host_valid wins; display is granted only when host_valid = 0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle host_valid && !host_ready.
  - Clears on host grant, when host_valid = 0, and on entering BLANK.
- Latency:
  - Grant at edge N drives ram_* at edge N.
  - Read data appears on ram_rdata in cycle N+1.
  - disp_rvalid / host_rvalid and rdata are registered at edge N+2, i.e. 2-cycle request-to-data.
  - Writes produce no rvalid.
  - Exactly one rvalid pulse per accepted read, in grant order; no reordering.
- Tag pipe: a 2-stage shift register of {valid, owner} steers ram_rdata to the correct port. Back-to-back reads from alternating owners are supported every cycle.
- Idle cycle: ram_en = 0. ram_addr and ram_wdata hold their previous values.
- Simultaneous blank transition and requests: arbitration uses the old mode for that cycle.
- Asynchronous reset mid-operation: in-flight reads are discarded, rvalids drop immediately, and no RAM command is issued until reset is released.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined:
  - Adds output port disp_stall_cnt, 16-bit: a saturating count of cycles with disp_valid && !disp_ready, cleared by reset only.
  - Adds output port host_starved, 1-bit sticky: set when the starve counter reaches STARVE_LIMIT, cleared by reset only.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - the VGA timing constants: 640/16/96/48 pixels and 480/10/2/33 lines;
  - the mode enum {ACTIVE, BLANK};
  - the owner enum {OWN_DISP, OWN_HOST};
  - the default ADDR_W and DATA_W.
- Sub-module vram_rd_tag_pipe is the 2-stage return-path tag shift register with data steering.

Test Plan:
- blank = 0; disp_valid and host_valid both held high; STARVE_LIMIT = 8 -> display granted for 8 cycles, host granted on the 9th with disp_ready = 0, then the pattern repeats.
- blank = 1; both valid -> host granted every cycle; disp_ready stays 0 until host_valid drops.
- Host write addr 0x0010 data 0xA5, then host read addr 0x0010 -> ram_we = 1 at the write grant; host_rvalid = 1 with host_rdata = 0xA5 exactly 2 cycles after the read grant.
- Alternating display read 0x0100 and host read 0x0200 on consecutive cycles (RAM model returns the low address byte) -> disp_rdata = 0x00 and host_rdata = 0x00 pulses arrive in order with no cross-steering; a second run with addresses 0x01A0 / 0x02B0 gives 0xA0 / 0xB0.
- Assert rst_n = 0 one cycle after a display read grant -> disp_rvalid never pulses, all outputs are 0, and the first post-reset grant behaves normally.
- With VRAM_ARB_STATS_EN: 20 refused display cycles -> disp_stall_cnt = 20; host_starved = 1 after the first forced host grant.
